// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: datapath width, reset PC, fetch FSM states
// and the fetch queue entry layout.
package rv_core_pkg;

   localparam int unsigned WIDTH_DATA        = 32;
   localparam logic [WIDTH_DATA-1:0] RESET_PC = 32'h0000_0000;

   // Fetch queue geometry; count spans 0..FETCH_QUEUE_DEPTH.
   localparam int unsigned FETCH_QUEUE_DEPTH = 2;
   localparam int unsigned FETCH_COUNT_W     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [WIDTH_DATA-1:0] pc;
      logic [WIDTH_DATA-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO between instruction fetch and decode.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   push_i, data_i   write request and entry (ignored when full without pop)
//   pop_i            consume head (ignored when empty)
//   flush_i          discard all entries; overrides push/pop
//   head_o           entry at the head of the queue
//   count_o          number of valid entries (0..2)
module fetch_queue
   import rv_core_pkg::*;
#(
   parameter int unsigned WIDTH_ENTRY = 2 * rv_core_pkg::WIDTH_DATA
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH_ENTRY-1:0]   data_i,
   output logic [WIDTH_ENTRY-1:0]   head_o,
   output logic [FETCH_COUNT_W-1:0] count_o
);

   localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;

   logic [WIDTH_ENTRY-1:0]   mem_q [DEPTH];
   logic                     rd_ptr_q;
   logic                     wr_ptr_q;
   logic [FETCH_COUNT_W-1:0] count_q;
   logic                     push_ok;
   logic                     pop_ok;

   // A push into a full queue is legal only when the head leaves this cycle.
   assign pop_ok  = pop_i && (count_q != '0);
   assign push_ok = push_i && ((count_q < FETCH_COUNT_W'(DEPTH)) || pop_ok);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + FETCH_COUNT_W'(1);
            2'b01:   count_q <= count_q - FETCH_COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// instruction memory, and buffers fetched words toward decode.
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   enable_i                 1 = fetch, 0 = hold (queued words still drain)
//   imem_addr_o              memory address, always the PC register
//   imem_instruction_i       same-cycle memory read data
//   redirect_i/redirect_pc_i one-cycle flush-and-restart request and target
//   fetch_valid_o/ready_i    valid/ready handshake toward decode
//   fetch_instr_o/fetch_pc_o head instruction and its PC
//   fault_o                  sticky misaligned-redirect fault
module fetch_controller
   import rv_core_pkg::*;
#(
   parameter int unsigned           WIDTH_DATA = rv_core_pkg::WIDTH_DATA,
   parameter logic [WIDTH_DATA-1:0] RESET_PC   = rv_core_pkg::RESET_PC
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  enable_i,
   output logic [WIDTH_DATA-1:0] imem_addr_o,
   input  logic [WIDTH_DATA-1:0] imem_instruction_i,
   input  logic                  redirect_i,
   input  logic [WIDTH_DATA-1:0] redirect_pc_i,
   output logic                  fetch_valid_o,
   input  logic                  fetch_ready_i,
   output logic [WIDTH_DATA-1:0] fetch_instr_o,
   output logic [WIDTH_DATA-1:0] fetch_pc_o,
   output logic                  fault_o
);

   localparam int unsigned WIDTH_ENTRY = 2 * WIDTH_DATA;

   fetch_state_e             state_q;
   fetch_state_e             state_d;
   logic [WIDTH_DATA-1:0]    pc_q;
   logic [WIDTH_DATA-1:0]    pc_d;
   logic                     push_c;
   logic                     pop_c;
   logic                     flush_c;
   logic                     redirect_ok_c;
   logic                     redirect_bad_c;
   logic                     room_c;
   logic [FETCH_COUNT_W-1:0] queue_count;
   logic [WIDTH_ENTRY-1:0]   queue_head;

   // Redirects are ignored once faulted; only reset leaves FAULT.
   assign redirect_ok_c  = redirect_i && (redirect_pc_i[1:0] == 2'b00) && (state_q != ST_FAULT);
   assign redirect_bad_c = redirect_i && (redirect_pc_i[1:0] != 2'b00) && (state_q != ST_FAULT);

   // Valid depends only on registers, so a ready that follows valid is loop-free.
   assign fetch_valid_o = (queue_count != '0) && (state_q != ST_FAULT);
   assign pop_c         = fetch_valid_o && fetch_ready_i;
   assign room_c        = (queue_count < FETCH_COUNT_W'(FETCH_QUEUE_DEPTH)) || pop_c;

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, PC update and queue control.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push_c  = 1'b0;
      flush_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (redirect_bad_c) begin
               state_d = ST_FAULT;
            end else if (enable_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (redirect_bad_c) begin
               state_d = ST_FAULT;
            end else if (!enable_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Redirect beats push; a same-cycle pop still completes inside the queue.
      if (redirect_ok_c) begin
         flush_c = 1'b1;
         pc_d    = redirect_pc_i;
      end else if (redirect_bad_c) begin
         flush_c = 1'b1;
      end else if ((state_q == ST_RUN) && enable_i && room_c) begin
         push_c = 1'b1;
         pc_d   = pc_q + WIDTH_DATA'(4);
      end
   end

   // Program counter; wraps modulo 2^WIDTH_DATA.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .WIDTH_ENTRY (WIDTH_ENTRY)
   ) u_fetch_queue (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .data_i  ({pc_q, imem_instruction_i}),
      .head_o  (queue_head),
      .count_o (queue_count)
   );

   assign imem_addr_o   = pc_q;
   assign fetch_pc_o    = queue_head[WIDTH_ENTRY-1:WIDTH_DATA];
   assign fetch_instr_o = queue_head[WIDTH_DATA-1:0];
   assign fault_o       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a random phase, with a
// stream-level scoreboard of the instructions decode should receive.
module tb_fetch_controller;
   import rv_core_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   // Reference: decode sees the word stream starting at the latest restart
   // point (reset or aligned redirect), ascending by 4 modulo 2^32.
   fetch_entry_t exp_q[$];
   logic [31:0]  stream_pc;
   logic         model_fault;

   fetch_controller #(
      .WIDTH_DATA (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .enable_i           (enable),
      .imem_addr_o        (imem_addr),
      .imem_instruction_i (imem_instruction),
      .redirect_i         (redirect),
      .redirect_pc_i      (redirect_pc),
      .fetch_valid_o      (fetch_valid),
      .fetch_ready_i      (fetch_ready),
      .fetch_instr_o      (fetch_instr),
      .fetch_pc_o         (fetch_pc),
      .fault_o            (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Combinational instruction memory.
   always_comb imem_instruction = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic top_up();
      fetch_entry_t e;
      while (exp_q.size() < 4) begin
         e.pc    = stream_pc;
         e.instr = mem_word(stream_pc);
         exp_q.push_back(e);
         stream_pc = stream_pc + 32'd4;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      stream_pc   = 32'h0000_0000;
      model_fault = 1'b0;
      top_up();
   endtask

   // Drive one cycle of inputs, then update the model after the edge.
   task automatic cycle(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
      enable      = en;
      fetch_ready = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      if (redir && !model_fault) begin
         exp_q.delete();
         if (rpc[1:0] == 2'b00) stream_pc = rpc;
         else model_fault = 1'b1;
      end
      top_up();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
      check({tag, "_addr"},  imem_addr,  32'h0000_0000);
      check({tag, "_instr"}, fetch_instr, 32'd0);
      check({tag, "_pc"},    fetch_pc,    32'd0);
      check({tag, "_fault"}, 32'(fault),  32'd0);
   endtask

   // Monitor: every handshake must deliver the next word of the stream.
   always @(negedge clk) begin
      if (rst_n) begin
         if (model_fault) begin
            n_checks++;
            if (fetch_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL fault_valid: got valid=%b expected 0 at %0t", fetch_valid, $time);
            end
         end else if (fetch_valid && fetch_ready) begin
            n_checks++;
            n_pops++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream_empty: got pc=%h with no expected word at %0t", fetch_pc, $time);
            end else begin
               fetch_entry_t e;
               e = exp_q.pop_front();
               if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin
                  n_fail++;
                  $display("FAIL stream: got pc=%h instr=%h expected pc=%h instr=%h at %0t",
                           fetch_pc, fetch_instr, e.pc, e.instr, $time);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a0;
      logic        en;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;

      rst_n       = 1'b0;
      enable      = 1'b0;
      fetch_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Start latency, then fill under backpressure.
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("start_latency_valid", 32'(fetch_valid), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("first_valid", 32'(fetch_valid), 32'd1);
      check("first_pc", fetch_pc, 32'h0);
      check("first_addr", imem_addr, 32'h4);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("fill_addr", imem_addr, 32'h8);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("bp_addr_hold", imem_addr, 32'h8);
      check("bp_head_pc", fetch_pc, 32'h0);

      // Release backpressure: one word per cycle, no bubbles.
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("release_head_pc", fetch_pc, 32'h4);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'd0);
         check("no_bubble", 32'(fetch_valid), 32'd1);
      end

      // Redirect while full with ready high.
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 32'h40);
      check("redir_bubble", 32'(fetch_valid), 32'd0);
      check("redir_addr", imem_addr, 32'h40);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("redir_pc0", fetch_pc, 32'h40);
      check("redir_valid", 32'(fetch_valid), 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("redir_pc1", fetch_pc, 32'h44);

      // PC wrap.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("wrap_bubble", 32'(fetch_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("wrap_pc0", fetch_pc, 32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("wrap_pc1", fetch_pc, 32'h0);

      // Enable drop: queue kept while held, then drained by decode.
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      a0 = imem_addr;
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      check("hold_addr", imem_addr, a0);
      check("hold_valid", 32'(fetch_valid), 32'd1);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("drained_valid", 32'(fetch_valid), 32'd0);
      check("drained_addr", imem_addr, a0);

      // Random traffic with aligned redirects.
      for (int i = 0; i < 600; i++) begin
         en    = ($urandom % 10) != 0;
         rdy   = ($urandom % 10) < 7;
         redir = ($urandom % 25) == 0;
         rpc   = $urandom & 32'hFFFF_FFFC;
         if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
         cycle(en, rdy, redir, rpc);
      end
      check("random_throughput", 32'(n_pops >= 150), 32'd1);

      // Asynchronous reset between edges.
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      #3;
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("restart_latency", 32'(fetch_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("restart_valid", 32'(fetch_valid), 32'd1);
      check("restart_pc", fetch_pc, 32'h0);

      // Misaligned redirect: sticky fault, PC frozen, no output.
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0);
      a0 = imem_addr;
      cycle(1'b1, 1'b1, 1'b1, 32'h42);
      check("fault_set", 32'(fault), 32'd1);
      check("fault_no_valid", 32'(fetch_valid), 32'd0);
      check("fault_addr", imem_addr, a0);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_addr_sticky", imem_addr, a0);
      rst_n = 1'b0;
      #1;
      check("fault_cleared", 32'(fault), 32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
